// File: rtl/myproject_dense_mac_seq.sv
//------------------------------------------------------------------------------
// myproject_dense_mac_seq : one dense-layer neuron computed by a time-shared
// 12s x 8s multiplier with a saturating accumulator.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module myproject_dense_mac_seq #(
  parameter int N_IN   = 16,
  parameter int IDX_W  = 4,
  parameter int DIN_W  = 12,
  parameter int W_W    = 8,
  parameter int PROD_W = 19,
  parameter int ACC_W  = 24
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     ap_start,
  output logic                     ap_idle,
  output logic                     ap_done,
  output logic                     ap_ready,
  output logic                     rd_en,
  output logic [IDX_W-1:0]         rd_addr,
  input  logic signed [DIN_W-1:0]  x_data,
  input  logic signed [W_W-1:0]    w_data,
  input  logic signed [ACC_W-1:0]  bias,
  output logic signed [ACC_W-1:0]  res,
  output logic                     ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                       state, state_nxt;
  logic [IDX_W-1:0]             cnt;
  logic                         drain_cnt;
  logic                         rv;
  logic                         pv;
  logic signed [PROD_W-1:0]     prod_q;
  logic signed [DIN_W+W_W-1:0]  prod_full;
  logic signed [ACC_W-1:0]      acc, acc_nxt;
  logic                         run_ovf, run_ovf_nxt;
  logic [ACC_W:0]               sum;
  logic                         clip;

  always_comb begin
    state_nxt = state;
    ap_idle   = 1'b0;
    ap_done   = 1'b0;
    rd_en     = 1'b0;
    case (state)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) state_nxt = S_RUN;
      end
      S_RUN: begin
        rd_en = 1'b1;
        if (cnt == LAST_IDX) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt) state_nxt = S_DONE;
      end
      S_DONE: begin
        ap_done   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ap_ready = ap_done;
  assign rd_addr  = cnt;

  // Full product is computed in DIN_W+W_W bits; only the low PROD_W bits are kept (wrap).
  assign prod_full = x_data * w_data;

  // One guard bit is enough to detect overflow of a single add.
  assign sum  = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){prod_q[PROD_W-1]}}, prod_q};
  assign clip = sum[ACC_W] ^ sum[ACC_W-1];

  always_comb begin
    acc_nxt     = acc;
    run_ovf_nxt = run_ovf;
    if (pv) begin
      if (clip) begin
        acc_nxt     = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        run_ovf_nxt = 1'b1;
      end else begin
        acc_nxt = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      drain_cnt <= 1'b0;
      rv        <= 1'b0;
      pv        <= 1'b0;
      prod_q    <= '0;
      acc       <= '0;
      run_ovf   <= 1'b0;
      res       <= '0;
      ovf       <= 1'b0;
    end else begin
      state   <= state_nxt;
      rv      <= rd_en;
      pv      <= rv;
      acc     <= acc_nxt;
      run_ovf <= run_ovf_nxt;
      if (rv) prod_q <= prod_full[PROD_W-1:0];

      if (state == S_IDLE && ap_start) begin
        acc       <= bias;
        run_ovf   <= 1'b0;
        cnt       <= '0;
        drain_cnt <= 1'b0;
      end

      // cnt stops on the last index so rd_addr never leaves 0..N_IN-1.
      if (state == S_RUN && cnt != LAST_IDX) cnt <= cnt + 1'b1;

      if (state == S_DRAIN) begin
        drain_cnt <= 1'b1;
        if (drain_cnt) begin
          res <= acc_nxt;
          ovf <= run_ovf_nxt;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_myproject_dense_mac_seq.sv
//------------------------------------------------------------------------------
// tb_myproject_dense_mac_seq : directed, table-driven bench for the MAC neuron.
//------------------------------------------------------------------------------
`default_nettype none

module tb_myproject_dense_mac_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: N_IN = 16
  logic               start_a = 1'b0;
  logic               idle_a, done_a, ready_a, rd_en_a;
  logic [3:0]         addr_a;
  logic signed [11:0] x_a = '0;
  logic signed [7:0]  w_a = '0;
  logic signed [23:0] bias_a = '0;
  logic signed [23:0] res_a;
  logic               ovf_a;

  // DUT B: N_IN = 1
  logic               start_b = 1'b0;
  logic               idle_b, done_b, ready_b, rd_en_b;
  logic [3:0]         addr_b;
  logic signed [11:0] x_b = '0;
  logic signed [7:0]  w_b = '0;
  logic signed [23:0] bias_b = '0;
  logic signed [23:0] res_b;
  logic               ovf_b;

  myproject_dense_mac_seq #(.N_IN(16)) dut_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start_a), .ap_idle(idle_a),
    .ap_done(done_a), .ap_ready(ready_a), .rd_en(rd_en_a), .rd_addr(addr_a),
    .x_data(x_a), .w_data(w_a), .bias(bias_a), .res(res_a), .ovf(ovf_a));

  myproject_dense_mac_seq #(.N_IN(1)) dut_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start_b), .ap_idle(idle_b),
    .ap_done(done_b), .ap_ready(ready_b), .rd_en(rd_en_b), .rd_addr(addr_b),
    .x_data(x_b), .w_data(w_b), .bias(bias_b), .res(res_b), .ovf(ovf_b));

  // Registered-read input/weight buffers shared by both DUTs.
  logic signed [11:0] xmem [16];
  logic signed [7:0]  wmem [16];
  always @(posedge clk) begin
    if (rd_en_a) begin x_a <= xmem[addr_a]; w_a <= wmem[addr_a]; end
    if (rd_en_b) begin x_b <= xmem[addr_b]; w_b <= wmem[addr_b]; end
  end

  typedef struct {
    string name;
    int    bias;
    int    xb;
    int    xs;
    int    wv;
    int    exp_res;
    int    exp_ovf;
  } vec_t;

  vec_t vecs [6];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int xb, input int xs, input int wv);
    for (int k = 0; k < 16; k++) begin
      xmem[k] = 12'(xb + k * xs);
      wmem[k] = 8'(wv);
    end
  endtask

  // One run on DUT A; optional stray ap_start pulse (with a different bias) in cycle pulse_cyc.
  task automatic run_a(input string name, input int b, input int exp_res, input int exp_ovf,
                       input int pulse_cyc);
    int done_cyc = -1;
    int n_done   = 0;
    int rd_cnt   = 0;
    int addr_ok  = 1;
    @(negedge clk);
    chk({name, " idle@0"}, idle_a, 1);
    bias_a  = 24'(b);
    start_a = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (rd_en_a) begin
        rd_cnt++;
        if (int'(addr_a) != cyc - 1 || cyc > 16) addr_ok = 0;
      end
      if (done_a) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
        if (!ready_a) addr_ok = 0;
      end
      if (cyc == pulse_cyc) begin
        start_a = 1'b1;
        bias_a  = 24'(b + 12345);
      end else begin
        start_a = 1'b0;
      end
    end
    chk({name, " done_cycle"}, done_cyc, 19);
    chk({name, " done_count"}, n_done, 1);
    chk({name, " rd_en/addr"}, rd_cnt * 2 + addr_ok, 33);
    chk({name, " res"}, longint'(res_a), exp_res);
    chk({name, " ovf"}, ovf_a, exp_ovf);
  endtask

  initial begin
    logic [63:0] done_m, idle_m, done_exp, idle_exp;
    int n_done, rd_cnt, done_cyc;

    vecs[0] = '{"ones",      0,        1,     0,  1,   16,       0};
    vecs[1] = '{"wrap",      0,        -2048, 0,  -128, -4194304, 0};
    vecs[2] = '{"neg_sat",   -8000000, -2048, 0,  127, -8388608, 1};
    vecs[3] = '{"ramp",      100,      0,     1,  3,   460,      0};
    vecs[4] = '{"pos_sat",   8000000,  2047,  0,  127, 8388607,  1};
    vecs[5] = '{"clip_cont", 8388605,  7,     -1, 1,   8388571,  1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst idle", idle_a, 1);
    chk("rst done", done_a, 0);
    chk("rst ready", ready_a, 0);
    chk("rst rd_en", rd_en_a, 0);
    chk("rst addr", addr_a, 0);
    chk("rst res", res_a, 0);
    chk("rst ovf", ovf_a, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      load(vecs[i].xb, vecs[i].xs, vecs[i].wv);
      run_a(vecs[i].name, vecs[i].bias, vecs[i].exp_res, vecs[i].exp_ovf, 0);
    end

    // ap_start held high across three back-to-back runs
    load(1, 0, 1);
    done_m = '0; idle_m = '0;
    @(negedge clk);
    idle_m[0] = idle_a;
    bias_a  = 24'sd0;
    start_a = 1'b1;
    for (int cyc = 1; cyc <= 59; cyc++) begin
      @(negedge clk);
      done_m[cyc] = done_a;
      idle_m[cyc] = idle_a;
      if (done_a) chk("held res", longint'(res_a), 16);
    end
    start_a = 1'b0;
    done_exp = '0; done_exp[19] = 1'b1; done_exp[39] = 1'b1; done_exp[59] = 1'b1;
    idle_exp = '0; idle_exp[0] = 1'b1;  idle_exp[20] = 1'b1; idle_exp[40] = 1'b1;
    chk("held done mask", longint'(done_m), longint'(done_exp));
    chk("held idle mask", longint'(idle_m), longint'(idle_exp));
    repeat (3) @(negedge clk);

    // Asynchronous reset in cycle 8 of a run
    load(0, 1, 3);
    @(negedge clk);
    bias_a  = 24'sd100;
    start_a = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort rd_en", rd_en_a, 0);
    chk("abort res", res_a, 0);
    chk("abort ovf", ovf_a, 0);
    chk("abort idle", idle_a, 1);
    n_done = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clk);
      if (cyc == 2) rst_n = 1'b1;
      if (done_a) n_done++;
    end
    chk("abort no done", n_done, 0);
    run_a("restart", 100, 460, 0, 0);

    // Stray ap_start in cycle 5 is ignored
    run_a("stray_start", 100, 460, 0, 5);

    // N_IN = 1 instance
    load(-2048, 0, -128);
    rd_cnt = 0; done_cyc = -1;
    @(negedge clk);
    chk("n1 idle@0", idle_b, 1);
    bias_b  = 24'sd0;
    start_b = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (rd_en_b) rd_cnt += (addr_b == 4'd0 && cyc == 1) ? 1 : 10;
      if (done_b && done_cyc < 0) done_cyc = cyc;
    end
    chk("n1 rd_en", rd_cnt, 1);
    chk("n1 done_cycle", done_cyc, 4);
    chk("n1 res", longint'(res_b), -262144);
    chk("n1 ovf", ovf_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
